pifo_stfq_rank_enqueue: RTL

Upstream stage of the root PIFO calendar. The block accepts packet descriptors (buffer address, flow id, length) over a valid/ready handshake and computes a start-time fair queuing (STFQ) rank for each one. It packs each result into the 32-bit root element format (valid bit 31, rank 30:12, buffer address 11:0) and drives the calendar's insert strobe. It also tracks calendar occupancy with its own credit counter, so the calendar is never over-filled while inserts are in flight.

---
 rtl/pifo_pkg.sv | 32 +++
 rtl/pifo_stfq_flow_table.sv | 49 ++++
 rtl/pifo_stfq_rank_enqueue.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pifo_pkg.sv
// Shared PIFO definitions: root element layout, rank/address/flow types and rank arithmetic.
package pifo_pkg;

  localparam int unsigned RANK_START_POS = 12;
  localparam int unsigned RANK_END_POS   = 30;
  localparam int unsigned VALID_POS      = 31;

  localparam int unsigned RANK_W = RANK_END_POS - RANK_START_POS + 1;
  localparam int unsigned ADDR_W = RANK_START_POS;
  localparam int unsigned ELEM_W = VALID_POS + 1;
  localparam int unsigned FLOW_W = 4;
  localparam int unsigned LEN_W  = 11;

  typedef logic [RANK_W-1:0] rank_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [FLOW_W-1:0] flow_t;
  typedef logic [LEN_W-1:0]  len_t;

  typedef struct packed {
    logic  valid;
    rank_t rank;
    addr_t addr;
  } pifo_elem_t;

  // Rank + length, clamped at the largest rank instead of wrapping.
  function automatic rank_t sat_add(input rank_t a, input len_t b);
    logic [RANK_W:0] sum;
    sum = {1'b0, a} + (RANK_W+1)'(b);
    return sum[RANK_W] ? '1 : sum[RANK_W-1:0];
  endfunction

endpackage

// File: rtl/pifo_stfq_flow_table.sv
// Per-flow STFQ state: last finish time and valid bit, with write-to-read
// forwarding and a bulk epoch clear of the valid bits.
module pifo_stfq_flow_table
  import pifo_pkg::*;
#(
  parameter int unsigned NUM_FLOWS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLOW_W-1:0] rd_flow,
  output logic [RANK_W-1:0] rd_finish_c,
  output logic              rd_valid_c,
  input  logic              wr_en,
  input  logic [FLOW_W-1:0] wr_flow,
  input  logic [RANK_W-1:0] wr_finish,
  input  logic              epoch_clr
);

  rank_t                last_finish_q [NUM_FLOWS];
  logic [NUM_FLOWS-1:0] valid_q;

  // Epoch clear wins over a same-cycle write: vt restarts at zero too.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (epoch_clr) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_flow] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      last_finish_q[wr_flow] <= wr_finish;
    end
  end

  // A flow being written this cycle is read back as its new finish time.
  always_comb begin
    rd_finish_c = last_finish_q[rd_flow];
    rd_valid_c  = valid_q[rd_flow];
    if (wr_en && (wr_flow == rd_flow)) begin
      rd_finish_c = wr_finish;
      rd_valid_c  = 1'b1;
    end
  end

endmodule

// File: rtl/pifo_stfq_rank_enqueue.sv
// STFQ rank computation and credit-gated insert into the root PIFO calendar.
// Optional per-flow length weighting is enabled with PIFO_STFQ_WEIGHT_EN.
module pifo_stfq_rank_enqueue
  import pifo_pkg::*;
#(
  parameter int unsigned PIFO_CALENDAR_SIZE        = 1024,
  parameter int unsigned PIFO_CALENDAR_INDEX_WIDTH = 10,
  parameter int unsigned OCC_WIDTH                 = 11,
  parameter int unsigned BUFFER_ADDR_WIDTH         = 12,
  parameter int unsigned PIFO_RANK_WIDTH           = 19,
  parameter int unsigned PIFO_ROOT_WIDTH           = 32,
  parameter int unsigned FLOW_ID_WIDTH             = 4,
  parameter int unsigned NUM_FLOWS                 = 16,
  parameter int unsigned PKT_LEN_WIDTH             = 11
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_axis_desc_valid,
  output logic                         s_axis_desc_ready,
  input  logic [BUFFER_ADDR_WIDTH-1:0] s_axis_desc_addr,
  input  logic [FLOW_ID_WIDTH-1:0]     s_axis_desc_flow,
  input  logic [PKT_LEN_WIDTH-1:0]     s_axis_desc_len,
  output logic [PIFO_ROOT_WIDTH-1:0]   m_axis_pifo_info_root,
  output logic                         m_axis_insert_en,
  input  logic                         s_axis_pop_en,
  input  logic [PIFO_RANK_WIDTH-1:0]   s_axis_pop_rank,
  output logic [OCC_WIDTH-1:0]         m_axis_occupancy
`ifdef PIFO_STFQ_WEIGHT_EN
  ,
  input  logic                         cfg_wr_valid,
  input  logic [FLOW_ID_WIDTH-1:0]     cfg_wr_flow,
  input  logic [2:0]                   cfg_wr_shift
`endif
);

  if (OCC_WIDTH <= PIFO_CALENDAR_INDEX_WIDTH) begin : g_bad_occ_width
    $error("OCC_WIDTH cannot represent a full calendar");
  end

  logic                 accept;
  logic                 pop_dec;
  logic                 epoch_clr;
  logic [OCC_WIDTH-1:0] occ_q;
  rank_t                vt_q;
  flow_t                in_flow;
  len_t                 len_eff;
  rank_t                rd_finish;
  logic                 rd_valid;

  logic  s1_valid_q;
  addr_t s1_addr_q;
  flow_t s1_flow_q;
  len_t  s1_len_q;
  rank_t s1_last_finish_q;
  logic  s1_flow_valid_q;

  rank_t      start_c;
  rank_t      finish_c;
  pifo_elem_t elem_c;
  logic       wr_en;

  assign s_axis_desc_ready = (occ_q < OCC_WIDTH'(PIFO_CALENDAR_SIZE)) & ~rst;
  assign accept            = s_axis_desc_valid & s_axis_desc_ready;
  assign pop_dec           = s_axis_pop_en & (occ_q != '0);
  assign epoch_clr         = (occ_q == '0) & ~accept;
  assign in_flow           = FLOW_W'(s_axis_desc_flow);
  assign m_axis_occupancy  = occ_q;

`ifdef PIFO_STFQ_WEIGHT_EN
  logic [2:0] shift_q [NUM_FLOWS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_FLOWS); i++) begin
        shift_q[i] <= '0;
      end
    end else if (cfg_wr_valid) begin
      shift_q[FLOW_W'(cfg_wr_flow)] <= cfg_wr_shift;
    end
  end

  assign len_eff = LEN_W'(s_axis_desc_len) >> shift_q[in_flow];
`else
  assign len_eff = LEN_W'(s_axis_desc_len);
`endif

  // Credits count accepted descriptors, so in-flight inserts are already reserved.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
    end else if (accept && !pop_dec) begin
      occ_q <= occ_q + OCC_WIDTH'(1);
    end else if (!accept && pop_dec) begin
      occ_q <= occ_q - OCC_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vt_q <= '0;
    end else if (epoch_clr) begin
      vt_q <= '0;
    end else if (s_axis_pop_en) begin
      vt_q <= RANK_W'(s_axis_pop_rank);
    end
  end

  pifo_stfq_flow_table #(
    .NUM_FLOWS (NUM_FLOWS)
  ) u_flow_table (
    .clk         (clk),
    .rst         (rst),
    .rd_flow     (in_flow),
    .rd_finish_c (rd_finish),
    .rd_valid_c  (rd_valid),
    .wr_en       (wr_en),
    .wr_flow     (s1_flow_q),
    .wr_finish   (finish_c),
    .epoch_clr   (epoch_clr)
  );

  // S1: descriptor and its flow state captured on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= accept;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_addr_q        <= ADDR_W'(s_axis_desc_addr);
      s1_flow_q        <= in_flow;
      s1_len_q         <= len_eff;
      s1_last_finish_q <= rd_finish;
      s1_flow_valid_q  <= rd_valid;
    end
  end

  // S2: start = max(vt, last_finish) for a known flow, else vt.
  always_comb begin
    start_c = vt_q;
    if (s1_flow_valid_q && (s1_last_finish_q > vt_q)) begin
      start_c = s1_last_finish_q;
    end
    finish_c     = sat_add(start_c, s1_len_q);
    elem_c.valid = 1'b1;
    elem_c.rank  = start_c;
    elem_c.addr  = s1_addr_q;
  end

  assign wr_en = s1_valid_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_insert_en      <= 1'b0;
      m_axis_pifo_info_root <= '0;
    end else begin
      m_axis_insert_en <= s1_valid_q;
      if (s1_valid_q) begin
        m_axis_pifo_info_root <= PIFO_ROOT_WIDTH'(ELEM_W'(elem_c));
      end
    end
  end

endmodule
